px_win_shr: RTL and testbench
=============================

// Module: px_win_shr
// PURPOSE
//  Parametrised pixel-window shift register feeding the median sorter. Holds a DEPTH-tap
//  sliding window of CH-channel pixels with valid/ready flow control on both sides. Pads
//  line edges by zero or by edge replication, so each line of L input pixels yields exactly
//  L centred windows. Sits between the pixel source and the median compare network.
// PARAMETERS
//  PX_W       8  bits per channel
//  CH         3  channels per pixel; pixel width PW = CH*PX_W
//  DEPTH      5  window taps; odd, >=1; HALF = (DEPTH-1)/2
//  EDGE_MODE  0  0 = zero padding, 1 = replicate edge pixel
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst        in   1           reset, asynchronous, active-low
//  in_valid   in   1           input pixel valid
//  in_ready   out  1           block accepts pixel this cycle
//  in_px      in   PW          input pixel
//  in_sol     in   1           qualifies in_px as first pixel of a line
//  in_eol     in   1           qualifies in_px as last pixel of a line (may coincide with sol)
//  out_valid  out  1           window valid
//  out_ready  in   1           downstream accepts window
//  out_taps   out  DEPTH*PW    tap k at [(k+1)*PW-1 : k*PW]; tap 0 newest, tap DEPTH-1 oldest
//  out_center out  PW          tap HALF
//  out_sol    out  1           first window of line (valid with out_valid)
//  out_eol    out  1           last window of line (valid with out_valid)
// BEHAVIOUR
//  Reset (rst=0, async): taps=0, fill=0, state=IDLE, out_valid/out_sol/out_eol=0.
//  adv = !out_valid || out_ready. in_ready = adv && state!=FLUSH. acc = in_valid && in_ready.
//  out_taps is the tap register itself; no extra latency: window updates on the shift edge.
//  States: IDLE (no open line), RUN (line open), FLUSH (emitting HALF trailing pad shifts).
//  IDLE: acc without sol -> pixel discarded, no shift. acc with sol -> line start.
//  Line start (acc && sol, in IDLE or RUN): tap0=in_px; taps 1..DEPTH-1 = 0 (mode 0) or in_px
//   (mode 1); fill=HALF+1; state=RUN. sol in RUN aborts the open line: no flush, no out_eol.
//  RUN, acc without sol: shift (tap k <= tap k-1, tap0 <= in_px), fill=min(fill+1,DEPTH).
//  acc with eol (after start/shift above): HALF>0 -> FLUSH, flush_cnt=HALF; HALF=0 -> IDLE.
//  FLUSH, on each adv: shift in pad (0 in mode 0, current tap0 in mode 1), flush_cnt-1;
//   at 0 -> IDLE, fill=0. in_valid ignored (in_ready=0) throughout FLUSH.
//  On every shift/line start with adv: out_valid <= (new fill == DEPTH); out_sol <= new fill
//   reached DEPTH from below; out_eol <= last flush shift, or eol pixel when HALF=0.
//  adv without shift: out_valid <= 0. While out_valid && !out_ready: all state frozen.
//  Windows per line = L for any L>=1, including L < HALF+1.
//  Reset mid-line or mid-FLUSH: state discarded immediately; next line needs sol.
// TESTING (DEPTH=5, CH=3, PX_W=8, all channels equal; windows listed oldest..newest)
//  1 EDGE_MODE=1, line 10..15, sol on 10, eol on 15, out_ready=1 -> 6 windows, first
//    [10,10,10,11,12] out_sol=1, center 10; last [13,14,15,15,15] out_eol=1; in_ready=0 2 cyc.
//  2 EDGE_MODE=0, same stimulus -> first [0,0,10,11,12], last [13,14,15,0,0], 6 windows.
//  3 Test 1 with out_ready=0 for 3 cycles mid-line -> out_taps held, in_ready=0,
//    output sequence identical to test 1, no pixel lost or duplicated.
//  4 EDGE_MODE=1, L=1 pixel 7 with sol+eol -> one window [7,7,7,7,7], out_sol=out_eol=1.
//  5 Pixels 1,2 without sol after reset -> discarded, out_valid stays 0; sol at pixel 3 of a
//    line after 2 open pixels -> no out_eol for aborted line, new line windows from sol pixel.
//  6 rst low during FLUSH -> out_valid=0 asynchronously, IDLE; following line matches test 1.

Source files
------------

// File: rtl/px_win_shr.sv
// Sliding DEPTH-tap pixel window with valid/ready on both sides and line-edge padding.
// Every line of L accepted pixels produces exactly L centred windows for the median sorter.
module px_win_shr #(
  parameter int PX_W      = 8,
  parameter int CH        = 3,
  parameter int DEPTH     = 5,
  parameter int EDGE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*PX_W-1:0]       in_px,
  input  logic                     in_sol,
  input  logic                     in_eol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH*CH*PX_W-1:0] out_taps,
  output logic [CH*PX_W-1:0]       out_center,
  output logic                     out_sol,
  output logic                     out_eol
);

  localparam int PW   = CH * PX_W;
  localparam int HALF = (DEPTH - 1) / 2;
  localparam int FW   = $clog2(DEPTH + 1);

  localparam logic [FW-1:0] FULL       = FW'(DEPTH);
  localparam logic [FW-1:0] START_FILL = FW'(HALF + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(HALF);
  localparam logic [FW-1:0] ONE        = FW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   taps [DEPTH];
  logic [FW-1:0]   fill, fill_n, fill_inc;
  logic [FW-1:0]   flush_cnt, flush_n;
  logic            adv, acc;
  logic            do_start, do_shift;
  logic [PW-1:0]   shift_px;
  logic            valid_n, sol_n, eol_n;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && (state != FLUSH);
  assign acc      = in_valid && in_ready;
  assign fill_inc = (fill == FULL) ? fill : fill + ONE;

  // Next-state decode; when the window is stalled (adv low) everything holds.
  always_comb begin
    state_n  = state;
    fill_n   = fill;
    flush_n  = flush_cnt;
    do_start = 1'b0;
    do_shift = 1'b0;
    shift_px = in_px;
    valid_n  = out_valid;
    sol_n    = out_sol;
    eol_n    = out_eol;
    if (adv) begin
      valid_n = 1'b0;
      sol_n   = 1'b0;
      eol_n   = 1'b0;
      case (state)
        IDLE, RUN: begin
          if (acc && in_sol) begin
            do_start = 1'b1;
            fill_n   = START_FILL;
            valid_n  = (START_FILL == FULL);
            sol_n    = valid_n;
            state_n  = RUN;
          end else if (acc && (state == RUN)) begin
            do_shift = 1'b1;
            fill_n   = fill_inc;
            valid_n  = (fill_inc == FULL);
            sol_n    = valid_n && (fill != FULL);
          end
          if (acc && in_eol && (in_sol || (state == RUN))) begin
            if (HALF > 0) begin
              state_n = FLUSH;
              flush_n = FLUSH_INIT;
            end else begin
              state_n = IDLE;
              fill_n  = '0;
              eol_n   = 1'b1;
            end
          end
        end
        FLUSH: begin
          do_shift = 1'b1;
          shift_px = (EDGE_MODE != 0) ? taps[0] : '0;
          valid_n  = (fill_inc == FULL);
          sol_n    = valid_n && (fill != FULL);
          flush_n  = flush_cnt - ONE;
          if (flush_cnt == ONE) begin
            state_n = IDLE;
            fill_n  = '0;
            eol_n   = 1'b1;
          end else begin
            fill_n  = fill_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fill      <= '0;
      flush_cnt <= '0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      state     <= state_n;
      fill      <= fill_n;
      flush_cnt <= flush_n;
      out_valid <= valid_n;
      out_sol   <= sol_n;
      out_eol   <= eol_n;
    end
  end

  // A line start preloads the older taps with the pad value so the first window is centred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) taps[k] <= '0;
    end else if (do_start) begin
      taps[0] <= in_px;
      for (int k = 1; k < DEPTH; k++) taps[k] <= (EDGE_MODE != 0) ? in_px : '0;
    end else if (do_shift) begin
      for (int k = DEPTH - 1; k > 0; k--) taps[k] <= taps[k-1];
      taps[0] <= shift_px;
    end
  end

  always_comb begin
    out_taps = '0;
    for (int k = 0; k < DEPTH; k++) out_taps[k*PW +: PW] = taps[k];
  end

  assign out_center = taps[HALF];

endmodule

// File: tb/tb_px_win_shr.sv
// Directed bench for px_win_shr: one replicate-edge and one zero-pad instance share stimulus,
// each checked cycle by cycle against hand-computed windows.
module tb_px_win_shr;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [23:0]  in_px = '0;
  logic         in_sol = 1'b0;
  logic         in_eol = 1'b0;
  logic         out_ready = 1'b1;

  logic         ir1, ov1, sol1, eol1;
  logic         ir0, ov0, sol0, eol0;
  logic [119:0] taps1, taps0;
  logic [23:0]  ctr1, ctr0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  px_win_shr #(.PX_W(8), .CH(3), .DEPTH(5), .EDGE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_px(in_px),
    .in_sol(in_sol), .in_eol(in_eol), .out_valid(ov1), .out_ready(out_ready),
    .out_taps(taps1), .out_center(ctr1), .out_sol(sol1), .out_eol(eol1)
  );

  px_win_shr #(.PX_W(8), .CH(3), .DEPTH(5), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_px(in_px),
    .in_sol(in_sol), .in_eol(in_eol), .out_valid(ov0), .out_ready(out_ready),
    .out_taps(taps0), .out_center(ctr0), .out_sol(sol0), .out_eol(eol0)
  );

  // One stimulus cycle: inputs, in_ready expected before the edge, outputs expected after it.
  // Windows are packed oldest byte in the MSB, newest in the LSB.
  typedef struct {
    bit          iv;
    logic [7:0]  px;
    bit          sol, eol, ory;
    bit          ir, ov, osol, oeol;
    logic [39:0] w1, w0;
  } row_t;

  row_t rows[$];

  function automatic logic [39:0] w5(input int a, b, c, d, e);
    return {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0]};
  endfunction

  function automatic logic [119:0] expand(input logic [39:0] w);
    logic [119:0] t;
    for (int k = 0; k < 5; k++) t[k*24 +: 24] = {3{w[k*8 +: 8]}};
    return t;
  endfunction

  task automatic add(input int iv, px, sol, eol, ory, ir, ov, osol, oeol,
                     input logic [39:0] w1, w0);
    row_t r;
    r.iv = (iv != 0);   r.px = px[7:0];
    r.sol = (sol != 0); r.eol = (eol != 0); r.ory = (ory != 0);
    r.ir = (ir != 0);   r.ov = (ov != 0);
    r.osol = (osol != 0); r.oeol = (oeol != 0);
    r.w1 = w1; r.w0 = w0;
    rows.push_back(r);
  endtask

  task automatic checkOutput(input string nm, input logic [119:0] act, input logic [119:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    row_t r;
    r = rows[idx];
    @(negedge clk);
    in_valid  = r.iv;
    in_px     = {3{r.px}};
    in_sol    = r.sol;
    in_eol    = r.eol;
    out_ready = r.ory;
    #1;
    checkOutput($sformatf("row%0d in_ready m1", idx), 120'(ir1), 120'(r.ir));
    checkOutput($sformatf("row%0d in_ready m0", idx), 120'(ir0), 120'(r.ir));
    @(posedge clk);
    #1;
    checkOutput($sformatf("row%0d out_valid m1", idx), 120'(ov1), 120'(r.ov));
    checkOutput($sformatf("row%0d out_valid m0", idx), 120'(ov0), 120'(r.ov));
    checkOutput($sformatf("row%0d out_sol m1", idx), 120'(sol1), 120'(r.osol && r.ov));
    checkOutput($sformatf("row%0d out_sol m0", idx), 120'(sol0), 120'(r.osol && r.ov));
    checkOutput($sformatf("row%0d out_eol m1", idx), 120'(eol1), 120'(r.oeol && r.ov));
    checkOutput($sformatf("row%0d out_eol m0", idx), 120'(eol0), 120'(r.oeol && r.ov));
    if (r.ov) begin
      checkOutput($sformatf("row%0d taps m1", idx), taps1, expand(r.w1));
      checkOutput($sformatf("row%0d taps m0", idx), taps0, expand(r.w0));
      checkOutput($sformatf("row%0d center m1", idx), 120'(ctr1), 120'({3{r.w1[23:16]}}));
      checkOutput($sformatf("row%0d center m0", idx), 120'(ctr0), 120'({3{r.w0[23:16]}}));
    end
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(i);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 120'({ov1, ov0}), 120'(0));
    checkOutput("reset sol/eol", 120'({sol1, eol1, sol0, eol0}), 120'(0));
    checkOutput("reset taps m1", taps1, 120'(0));
    checkOutput("reset taps m0", taps0, 120'(0));
    rst = 1'b1;
  endtask

  int t1_s, t1_e, t3_s, t3_e, t4_s, t4_e, t5_s, t5_e;

  initial begin
    // Line 10..15, free-flowing output.
    t1_s = rows.size();
    add(1, 10, 1, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 11, 0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 12, 0, 0, 1, 1, 1, 1, 0, w5(10,10,10,11,12), w5(0,0,10,11,12));
    add(1, 13, 0, 0, 1, 1, 1, 0, 0, w5(10,10,11,12,13), w5(0,10,11,12,13));
    add(1, 14, 0, 0, 1, 1, 1, 0, 0, w5(10,11,12,13,14), w5(10,11,12,13,14));
    add(1, 15, 0, 1, 1, 1, 1, 0, 0, w5(11,12,13,14,15), w5(11,12,13,14,15));
    add(1, 99, 0, 0, 1, 0, 1, 0, 0, w5(12,13,14,15,15), w5(12,13,14,15,0));
    add(1, 99, 0, 0, 1, 0, 1, 0, 1, w5(13,14,15,15,15), w5(13,14,15,0,0));
    add(0, 0,  0, 0, 1, 1, 0, 0, 0, '0, '0);
    t1_e = rows.size() - 1;
    // Same line with a 3-cycle downstream stall while 13 is offered.
    t3_s = rows.size();
    add(1, 10, 1, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 11, 0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 12, 0, 0, 1, 1, 1, 1, 0, w5(10,10,10,11,12), w5(0,0,10,11,12));
    for (int i = 0; i < 3; i++)
      add(1, 13, 0, 0, 0, 0, 1, 1, 0, w5(10,10,10,11,12), w5(0,0,10,11,12));
    add(1, 13, 0, 0, 1, 1, 1, 0, 0, w5(10,10,11,12,13), w5(0,10,11,12,13));
    add(1, 14, 0, 0, 1, 1, 1, 0, 0, w5(10,11,12,13,14), w5(10,11,12,13,14));
    add(1, 15, 0, 1, 1, 1, 1, 0, 0, w5(11,12,13,14,15), w5(11,12,13,14,15));
    add(0, 0,  0, 0, 1, 0, 1, 0, 0, w5(12,13,14,15,15), w5(12,13,14,15,0));
    add(0, 0,  0, 0, 1, 0, 1, 0, 1, w5(13,14,15,15,15), w5(13,14,15,0,0));
    add(0, 0,  0, 0, 1, 1, 0, 0, 0, '0, '0);
    t3_e = rows.size() - 1;
    // Single-pixel line.
    t4_s = rows.size();
    add(1, 7, 1, 1, 1, 1, 0, 0, 0, '0, '0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, '0, '0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 1, w5(7,7,7,7,7), w5(0,0,7,0,0));
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, '0, '0);
    t4_e = rows.size() - 1;
    // Pixels before any sol, then a line aborted by a new sol.
    t5_s = rows.size();
    add(1, 1,  0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 2,  0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 20, 1, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 21, 0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 30, 1, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 31, 0, 0, 1, 1, 0, 0, 0, '0, '0);
    add(1, 32, 0, 0, 1, 1, 1, 1, 0, w5(30,30,30,31,32), w5(0,0,30,31,32));
    add(1, 33, 0, 1, 1, 1, 1, 0, 0, w5(30,30,31,32,33), w5(0,30,31,32,33));
    add(0, 0,  0, 0, 1, 0, 1, 0, 0, w5(30,31,32,33,33), w5(30,31,32,33,0));
    add(0, 0,  0, 0, 1, 0, 1, 0, 1, w5(31,32,33,33,33), w5(31,32,33,0,0));
    add(0, 0,  0, 0, 1, 1, 0, 0, 0, '0, '0);
    t5_e = rows.size() - 1;

    doReset();
    runRows(t1_s, t1_e);
    runRows(t3_s, t3_e);
    runRows(t4_s, t4_e);
    doReset();
    runRows(t5_s, t5_e);

    // Reset asserted while the first flush window is on the output.
    runRows(t1_s, t1_s + 6);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("async reset out_valid", 120'({ov1, ov0}), 120'(0));
    checkOutput("async reset in_ready", 120'({ir1, ir0}), 120'(3));
    checkOutput("async reset out_eol", 120'({eol1, eol0}), 120'(0));
    @(negedge clk);
    rst = 1'b1;
    runRows(t1_s, t1_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
